uart_tx_arbiter: RTL and testbench

Shares the single uart_tx serializer between two byte sources: the protocol engine's response stream and the bus-slave TX FIFO. Each source has a one-byte holding register. Arbitration gives the protocol channel strict priority, with a starvation limiter that guarantees the slave channel a slot. The block tags bit 7 of every transmitted byte with its origin (1 = protocol, 0 = slave data) and sequences the uart_tx start/ready handshake.

---
 rtl/uart_tx_arbiter.sv | 146 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Two-channel byte arbiter in front of a single uart_tx serializer.
// Protocol bytes win by default; a burst limiter guarantees the slave channel a slot.
module uart_tx_arbiter #(
    parameter int MAX_BURST    = 4,
    parameter int WAIT_TIMEOUT = 3
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [7:0] i_prot_dat,
    input  logic       i_prot_valid,
    output logic       o_prot_ready,
    input  logic [7:0] i_slv_dat,
    input  logic       i_slv_valid,
    output logic       o_slv_ready,
    output logic [7:0] o_tx_dat,
    output logic       o_tx_start,
    input  logic       i_tx_ready,
    output logic       o_busy,
    output logic       o_last_src,
    output logic       o_err
);
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam int TW = (WAIT_TIMEOUT > 1) ? $clog2(WAIT_TIMEOUT) : 1;
    localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);
    localparam logic [TW-1:0] TO_LAST   = TW'(WAIT_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, WAIT_LOW, WAIT_HIGH} state_t;

    state_t          state_q, state_d;
    logic            full_p_q, full_p_d;
    logic            full_s_q, full_s_d;
    logic [6:0]      prot_reg_q, prot_reg_d;
    logic [6:0]      slv_reg_q, slv_reg_d;
    logic [BW-1:0]   burst_q, burst_d;
    logic [TW-1:0]   to_cnt_q, to_cnt_d;
    logic            start_q, start_d;
    logic [7:0]      tx_dat_q, tx_dat_d;
    logic            last_q, last_d;
    logic            err_q, err_d;

    // Bit 7 of both inputs is overwritten by the source tag.
    logic unused_bit7;
    assign unused_bit7 = i_prot_dat[7] ^ i_slv_dat[7];

    always_comb begin
        state_d    = state_q;
        full_p_d   = full_p_q;
        full_s_d   = full_s_q;
        prot_reg_d = prot_reg_q;
        slv_reg_d  = slv_reg_q;
        burst_d    = burst_q;
        to_cnt_d   = to_cnt_q;
        start_d    = 1'b0;
        tx_dat_d   = tx_dat_q;
        last_d     = last_q;
        err_d      = err_q;

        if (i_prot_valid && !full_p_q) begin
            full_p_d   = 1'b1;
            prot_reg_d = i_prot_dat[6:0];
        end
        if (i_slv_valid && !full_s_q) begin
            full_s_d  = 1'b1;
            slv_reg_d = i_slv_dat[6:0];
        end

        case (state_q)
            IDLE: begin
                if (i_tx_ready && (full_p_q || full_s_q)) begin
                    // A waiting slave byte wins once the protocol burst is exhausted.
                    if (full_s_q && (!full_p_q || burst_q >= BURST_MAX)) begin
                        full_s_d = 1'b0;
                        tx_dat_d = {1'b0, slv_reg_q};
                        last_d   = 1'b0;
                        burst_d  = '0;
                    end else begin
                        full_p_d = 1'b0;
                        tx_dat_d = {1'b1, prot_reg_q};
                        last_d   = 1'b1;
                        if (!full_s_q)
                            burst_d = '0;
                        else if (burst_q != BURST_MAX)
                            burst_d = burst_q + BW'(1);
                    end
                    start_d  = 1'b1;
                    to_cnt_d = '0;
                    state_d  = WAIT_LOW;
                end
            end
            WAIT_LOW: begin
                if (!i_tx_ready) begin
                    state_d = WAIT_HIGH;
                end else if (to_cnt_q == TO_LAST) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + TW'(1);
                end
            end
            WAIT_HIGH: begin
                if (i_tx_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q  <= IDLE;
            full_p_q <= 1'b0;
            full_s_q <= 1'b0;
            burst_q  <= '0;
            to_cnt_q <= '0;
            start_q  <= 1'b0;
            tx_dat_q <= '0;
            last_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            full_p_q <= full_p_d;
            full_s_q <= full_s_d;
            burst_q  <= burst_d;
            to_cnt_q <= to_cnt_d;
            start_q  <= start_d;
            tx_dat_q <= tx_dat_d;
            last_q   <= last_d;
            err_q    <= err_d;
        end
    end

    // Holding data is qualified by the full flags, so it needs no reset.
    always_ff @(posedge i_clk) begin
        prot_reg_q <= prot_reg_d;
        slv_reg_q  <= slv_reg_d;
    end

    assign o_prot_ready = !full_p_q;
    assign o_slv_ready  = !full_s_q;
    assign o_tx_dat     = tx_dat_q;
    assign o_tx_start   = start_q;
    assign o_last_src   = last_q;
    assign o_err        = err_q;
    assign o_busy       = (state_q != IDLE) || full_p_q || full_s_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized bench for uart_tx_arbiter against a queue-based reference model
// with a simple uart_tx responder; directed scenarios are interleaved.
module tb_uart_tx_arbiter;
    localparam int MAX_BURST    = 4;
    localparam int WAIT_TIMEOUT = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] prot_dat, slv_dat;
    logic       prot_valid, slv_valid, tx_ready;
    logic       prot_ready, slv_ready, tx_start, busy, last_src, err;
    logic [7:0] tx_dat;

    uart_tx_arbiter #(.MAX_BURST(MAX_BURST), .WAIT_TIMEOUT(WAIT_TIMEOUT)) dut (
        .i_clk(clk), .i_reset(rst),
        .i_prot_dat(prot_dat), .i_prot_valid(prot_valid), .o_prot_ready(prot_ready),
        .i_slv_dat(slv_dat), .i_slv_valid(slv_valid), .o_slv_ready(slv_ready),
        .o_tx_dat(tx_dat), .o_tx_start(tx_start), .i_tx_ready(tx_ready),
        .o_busy(busy), .o_last_src(last_src), .o_err(err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: holding registers are 1-deep queues, the sequencer is a phase number.
    logic [7:0] q_p[$];
    logic [7:0] q_s[$];
    int         phase, wl, burst;
    logic       e_start, e_last, e_err;
    logic [7:0] e_dat;
    logic       glog[$];

    // uart_tx responder and stimulus knobs
    int busy_cnt = 0;
    int busy_len = 0;
    bit stuck = 0;
    int p_pct = 50;
    int s_pct = 50;

    task automatic model_reset();
        q_p.delete(); q_s.delete();
        phase = 0; wl = 0; burst = 0;
        e_start = 0; e_last = 0; e_err = 0; e_dat = 8'h00;
    endtask

    task automatic model_edge();
        bit pf, sf, src;
        logic [7:0] d;
        pf = (q_p.size() != 0);
        sf = (q_s.size() != 0);
        e_start = 0;
        case (phase)
            0: if (tx_ready && (pf || sf)) begin
                src = !(sf && (!pf || burst >= MAX_BURST));
                if (src) begin
                    d = q_p.pop_front();
                    burst = sf ? ((burst < MAX_BURST) ? burst + 1 : MAX_BURST) : 0;
                end else begin
                    d = q_s.pop_front();
                    burst = 0;
                end
                e_start = 1; e_dat = {src, d[6:0]}; e_last = src;
                phase = 1; wl = 0;
            end
            1: if (!tx_ready) phase = 2;
               else begin
                   wl++;
                   if (wl >= WAIT_TIMEOUT) begin e_err = 1; phase = 0; end
               end
            2: if (tx_ready) phase = 0;
            default: phase = 0;
        endcase
        if (prot_valid && !pf) q_p.push_back(prot_dat);
        if (slv_valid && !sf) q_s.push_back(slv_dat);
    endtask

    task automatic check_outputs();
        chk("tx_start",   tx_start,   e_start);
        chk("tx_dat",     tx_dat,     e_dat);
        chk("last_src",   last_src,   e_last);
        chk("err",        err,        e_err);
        chk("prot_ready", prot_ready, q_p.size() == 0);
        chk("slv_ready",  slv_ready,  q_s.size() == 0);
        chk("busy",       busy,       (phase != 0) || q_p.size() != 0 || q_s.size() != 0);
    endtask

    task automatic step(input bit rnd, input bit pv, input logic [7:0] pd,
                        input bit sv, input logic [7:0] sd);
        @(negedge clk);
        check_outputs();
        if (tx_start) glog.push_back(last_src);
        if (!stuck) begin
            if (tx_start) begin
                tx_ready = 0;
                busy_cnt = (busy_len == 0) ? int'($urandom_range(1, 10)) : busy_len;
            end else if (!tx_ready) begin
                busy_cnt--;
                if (busy_cnt <= 0) tx_ready = 1;
            end
        end
        if (rnd) begin
            prot_valid = ($urandom_range(0, 99) < p_pct);
            prot_dat   = 8'($urandom_range(0, 255));
            slv_valid  = ($urandom_range(0, 99) < s_pct);
            slv_dat    = 8'($urandom_range(0, 255));
        end else begin
            prot_valid = pv; prot_dat = pd;
            slv_valid  = sv; slv_dat  = sd;
        end
        model_edge();
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 0, 8'h00, 0, 8'h00);
    endtask

    task automatic async_reset();
        #2 rst = 1;
        prot_valid = 0; slv_valid = 0; tx_ready = 1; busy_cnt = 0;
        model_reset();
        #1 check_outputs();
        @(negedge clk);
        rst = 0;
        model_edge();
    endtask

    initial begin
        rst = 1; prot_valid = 0; slv_valid = 0; prot_dat = 0; slv_dat = 0; tx_ready = 1;
        model_reset();
        #12 check_outputs();
        @(negedge clk);
        rst = 0;
        model_edge();
        idle(2);

        // Single protocol byte, uart busy for 10 cycles
        busy_len = 10;
        step(0, 1, 8'h41, 0, 8'h00);
        idle(2);
        chk("t1_start", tx_start, 1);
        chk("t1_dat", tx_dat, 8'hC1);
        chk("t1_src", last_src, 1);
        chk("t1_pready", prot_ready, 1);
        idle(1);
        chk("t1_pulse_width", tx_start, 0);
        idle(14);

        // Single slave byte with bit 7 set on input
        step(0, 0, 8'h00, 1, 8'hC5);
        idle(2);
        chk("t2_dat", tx_dat, 8'h45);
        chk("t2_src", last_src, 0);
        idle(14);

        // Both channels streaming continuously
        busy_len = 2; p_pct = 100; s_pct = 100;
        glog.delete();
        for (int i = 0; i < 300 && glog.size() < 10; i++) step(1, 0, 8'h00, 0, 8'h00);
        chk("t3_ngrants", glog.size() >= 10, 1);
        for (int i = 0; i < 10 && i < glog.size(); i++)
            chk($sformatf("t3_grant%0d", i), glog[i], (i % 5 == 4) ? 1'b0 : 1'b1);
        idle(40);

        // Slave byte arrives while a protocol byte is in flight
        busy_len = 6;
        glog.delete();
        step(0, 1, 8'h22, 0, 8'h00);
        idle(1);
        step(0, 0, 8'h00, 1, 8'h33);
        idle(16);
        chk("t4_ngrants", glog.size(), 2);
        chk("t4_last", last_src, 0);
        chk("t4_dat", tx_dat, 8'h33);

        // uart never drops ready: timeout flags a sticky error
        stuck = 1;
        step(0, 1, 8'h10, 0, 8'h00);
        idle(8);
        chk("t5_err", err, 1);
        chk("t5_idle", busy, 0);
        stuck = 0;
        step(0, 0, 8'h00, 1, 8'h5A);
        idle(16);
        chk("t5_after_dat", tx_dat, 8'h5A);
        chk("t5_err_sticky", err, 1);

        // Async reset while waiting for ready-high with both registers full
        busy_len = 10;
        step(0, 1, 8'h11, 1, 8'h22);
        idle(1);
        step(0, 1, 8'h33, 0, 8'h00);
        idle(2);
        chk("t6_pfull", prot_ready, 0);
        chk("t6_sfull", slv_ready, 0);
        async_reset();
        chk("t6_err_clr", err, 0);
        step(0, 1, 8'h7E, 0, 8'h00);
        idle(2);
        chk("t6_post_dat", tx_dat, 8'hFE);
        idle(14);

        // Random traffic
        busy_len = 0; p_pct = 40; s_pct = 40;
        repeat (1500) step(1, 0, 8'h00, 0, 8'h00);
        p_pct = 90; s_pct = 90;
        repeat (500) step(1, 0, 8'h00, 0, 8'h00);

        // Drain: everything accepted must have been transmitted
        for (int i = 0; i < 200 && (busy || q_p.size() != 0 || q_s.size() != 0); i++) idle(1);
        chk("drain_busy", busy, 0);
        chk("drain_queues", q_p.size() + q_s.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
